// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read bus between the fetch unit and instruction memory.
// The fetch unit raises mem_req with mem_addr. Memory answers with mem_rdata
// and mem_ack, and it may take any number of cycles to do so.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    // Fetch unit side: issues requests and consumes read data
    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    // Memory side: observes requests and returns read data
    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage that sits in front of the instruction register.
// It holds the PC and reads one instruction word per request over a req/ack
// bus. The word goes out on ir_in_o, and ir_w_o pulses for one cycle so the IR
// captures it. The unit then waits in HOLD until the control unit asks for the
// next instruction. If memory never acknowledges, a timeout sets a sticky
// fault flag and the unit returns to IDLE.
module instr_fetch_unit #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              next_i,
    input  logic              stall_i,
    input  logic              halt_i,
    input  logic              branch_valid_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    instr_fetch_unit_if.master mem_if,
    output logic [DATA_W-1:0] ir_in_o,
    output logic              ir_w_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              busy_o,
    output logic              fault_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] RESET_PC_V   = ADDR_W'(RESET_PC);
    // The counter reaching this value marks the last FETCH cycle in which an
    // ack is still accepted.
    localparam logic [7:0]        TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              ir_w_q, ir_w_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              fault_q, fault_d;
    logic [7:0]        wait_q, wait_d;

    // Compute the next state and register values. Each output register is
    // derived from the state being entered, so every output is registered.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        fault_d = fault_q;
        wait_d  = wait_q;

        case (state_q)
            IDLE: begin
                if (branch_valid_i) begin
                    pc_d = branch_addr_i;
                end
                if (start_i) begin
                    fault_d = 1'b0;
                end
                if (start_i && !stall_i) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (mem_if.mem_ack) begin
                    ir_d    = mem_if.mem_rdata;
                    wait_d  = 8'd0;
                    state_d = LOAD;
                end else if (wait_q == TIMEOUT_LAST) begin
                    fault_d = 1'b1;
                    wait_d  = 8'd0;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            LOAD: begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = HOLD;
            end

            HOLD: begin
                if (branch_valid_i) begin
                    pc_d = branch_addr_i;
                end
                if (halt_i) begin
                    state_d = IDLE;
                end else if (next_i && !stall_i) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        req_d  = (state_d == FETCH);
        busy_d = (state_d == FETCH) || (state_d == LOAD);
        ir_w_d = (state_d == LOAD);
    end

    // Hold the state and output registers. Reset is asynchronous so that an
    // outstanding request drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC_V;
            ir_q    <= '0;
            ir_w_q  <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_w_q  <= ir_w_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
        end
    end

    assign mem_if.mem_req  = req_q;
    assign mem_if.mem_addr = pc_q;
    assign ir_in_o         = ir_q;
    assign ir_w_o          = ir_w_q;
    assign pc_o            = pc_q;
    assign busy_o          = busy_q;
    assign fault_o         = fault_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction register (IR).
- Holds the program counter (PC) and fetches one 16-bit instruction word from instruction memory through a req/ack handshake. Memory latency is variable.
- Presents the word on ir_in and pulses ir_w for one cycle so the IR latches it.
- Advances only when the control unit asks for the next instruction. Accepts branch targets in the same 10-bit width as the IR BA field.

Parameters:
- ADDR_W, 10, PC and memory address width; matches the IR BA field.
- DATA_W, 16, instruction word width; matches the IR input.
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 15, maximum cycles to wait for mem_ack before raising fault (1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (rst=0 resets)
- start  in  1  leave IDLE and begin fetching at the current PC
- next  in  1  control unit finished the current instruction; fetch the next one
- stall  in  1  block the start of a new fetch
- halt  in  1  return to IDLE from HOLD
- branch_valid  in  1  load the PC with branch_addr
- branch_addr  in  ADDR_W  branch target
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  memory address; always equals pc
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1
- mem_ack  in  1  memory data valid
- ir_in  out  DATA_W  captured instruction; drives the IR input
- ir_w  out  1  IR write enable, one-cycle pulse
- pc  out  ADDR_W  current program counter
- busy  out  1  high in FETCH and LOAD
- fault  out  1  sticky memory-timeout flag

Behaviour:
- Reset values (asynchronous, rst=0): state IDLE, pc=RESET_PC, ir_in=0, ir_w=0, mem_req=0, busy=0, fault=0, wait counter=0.
- All outputs are registered. mem_addr is wired to pc.

States:
- IDLE:
  - branch_valid loads pc<=branch_addr.
  - start=1 and stall=0 -> FETCH. If branch_valid and start are asserted together, the fetch uses branch_addr.
  - fault clears on start.
- FETCH:
  - mem_req=1, busy=1; wait counter increments each cycle.
  - mem_ack=1 -> ir_in<=mem_rdata, counter cleared, state -> LOAD. mem_req drops on the same edge.
  - Counter reaches TIMEOUT with no ack -> fault<=1, mem_req<=0, state -> IDLE, pc unchanged.
  - branch_valid, next and halt are ignored in FETCH.
- LOAD (one cycle):
  - ir_w=1.
  - pc<=pc+1, modulo 2^ADDR_W (1023 wraps to 0).
  - -> HOLD unconditionally. The IR captures ir_in at the end of this cycle.
- HOLD:
  - ir_w=0 and busy=0; ir_in holds its value.
  - halt=1 -> IDLE. halt has priority over next.
  - branch_valid=1 -> pc<=branch_addr, taking precedence over the incremented PC.
  - next=1 and stall=0 -> FETCH. When branch_valid and next are asserted together, the fetch uses branch_addr.
  - next with stall=1 is dropped; the control unit must hold next until it is accepted.

Timing and boundary conditions:
- Latency: if start is sampled at edge N and mem_ack=1 on the first FETCH cycle, then ir_w=1 in the cycle after edge N+1 and the IR updates at edge N+2.
- mem_ack outside FETCH is ignored.
- mem_rdata is sampled only with mem_ack in FETCH.
- Reset asserted mid-FETCH: mem_req drops immediately (asynchronously), no ir_w pulse occurs, pc returns to RESET_PC.

Test Plan:
- Reset then basic fetch: rst=0 -> all outputs 0, pc=0. rst=1, start pulse, mem_ack after 2 FETCH cycles with mem_rdata=16'b0110101010110011 -> ir_in=16'b0110101010110011, exactly one ir_w pulse, pc=1, state HOLD, busy=0.
- Sequential fetch: in HOLD, next=1 with a zero-wait ack and mem_rdata=16'b0001011011110100 -> mem_addr=1 during FETCH, ir_in=16'b0001011011110100, pc=2.
- Branch with next: in HOLD, branch_valid=1, branch_addr=10'b1010110011, next=1 -> mem_addr=10'b1010110011 in FETCH, then pc=10'b1010110100 after LOAD. A branch_valid pulse during FETCH leaves pc unchanged.
- Stall and halt: next=1, stall=1 for 3 cycles -> no mem_req, state stays HOLD. Then halt=1 and next=1 together -> IDLE, no fetch.
- Timeout and wrap: no mem_ack for TIMEOUT cycles -> fault=1, IDLE, pc unchanged, ir_w never asserted; start clears fault. Separately, branch to 1023 then fetch -> pc=0 after LOAD.
- Reset mid-fetch: rst=0 during FETCH -> mem_req=0 immediately, pc=0, no ir_w; a mem_ack arriving after reset release in IDLE is ignored.
